// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard bus between the pipeline control (master) and the scoreboard (slave).
// Carries the ID instruction descriptor in and the stall/forward decisions out.
interface hazard_scoreboard_if #(
  parameter int DEPTH = 3,
  parameter int TW    = 3,
  parameter int CNT_W = 32
);
  localparam int SW = $clog2(DEPTH + 1);

  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [TW-1:0]    id_tuse_rs;
  logic [TW-1:0]    id_tuse_rt;
  logic [4:0]       id_dst;
  logic             id_we;
  logic [TW-1:0]    id_tnew;
  logic             id_md_start;
  logic             id_md_div;
  logic             id_md_use;
  logic [DEPTH-1:0] stage_wr_ok;

  logic             stall;
  logic [SW-1:0]    fwd_id_rs;
  logic [SW-1:0]    fwd_id_rt;
  logic [SW-1:0]    fwd_ex_rs;
  logic [SW-1:0]    fwd_ex_rt;
  logic             md_busy;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_dst, id_we, id_tnew,
           id_md_start, id_md_div, id_md_use, stage_wr_ok,
    input  stall, fwd_id_rs, fwd_id_rt, fwd_ex_rs, fwd_ex_rt, md_busy, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_dst, id_we, id_tnew,
           id_md_start, id_md_div, id_md_use, stage_wr_ok,
    output stall, fwd_id_rs, fwd_id_rt, fwd_ex_rs, fwd_ex_rt, md_busy, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard scoreboard: shadows the destination of every stage after ID,
// raises data and mult/div stalls, and picks the nearest ready forwarding source.
module hazard_scoreboard #(
  parameter int DEPTH      = 3,
  parameter int TW         = 3,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  hazard_scoreboard_if.slave bus
);
  localparam int SW     = $clog2(DEPTH + 1);
  localparam int MD_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int MW     = $clog2(MD_MAX + 1);

  // Index i of each shadow array describes pipeline stage k = i+1.
  logic [4:0]       dst_q  [DEPTH];
  logic [4:0]       dst_d  [DEPTH];
  logic [TW-1:0]    tnew_q [DEPTH];
  logic [TW-1:0]    tnew_d [DEPTH];
  logic [DEPTH-1:0] we_q, we_d;
  logic [4:0]       ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
  logic [MW-1:0]    md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [DEPTH-1:0] hit_id_rs, hit_id_rt, hit_ex_rs, hit_ex_rt;
  logic [DEPTH-1:0] data_hz;
  logic             data_stall, md_stall, md_busy, stall;
  logic [SW-1:0]    fwd_id_rs, fwd_id_rt, fwd_ex_rs, fwd_ex_rt;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign hit_id_rs[gi] = (bus.id_rs != 5'd0) && (bus.id_rs == dst_q[gi]) && we_q[gi];
      assign hit_id_rt[gi] = (bus.id_rt != 5'd0) && (bus.id_rt == dst_q[gi]) && we_q[gi];
      assign hit_ex_rs[gi] = (ex_rs_q != 5'd0) && (ex_rs_q == dst_q[gi]) && we_q[gi];
      assign hit_ex_rt[gi] = (ex_rt_q != 5'd0) && (ex_rt_q == dst_q[gi]) && we_q[gi];
      // Stalls look at every pending writer, whether or not it will actually commit.
      assign data_hz[gi] = (hit_id_rs[gi] && (bus.id_tuse_rs < tnew_q[gi])) ||
                           (hit_id_rt[gi] && (bus.id_tuse_rt < tnew_q[gi]));
    end
  endgenerate

  assign data_stall = |data_hz;
  assign md_busy    = (md_cnt_q != '0);
  assign md_stall   = (bus.id_md_use || bus.id_md_start) && md_busy;
  assign stall      = data_stall || md_stall;

  // Scan oldest to youngest so the youngest committing writer wins.
  always_comb begin
    fwd_id_rs = '0;
    fwd_id_rt = '0;
    fwd_ex_rs = '0;
    fwd_ex_rt = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hit_id_rs[i] && bus.stage_wr_ok[i])
        fwd_id_rs = (tnew_q[i] == '0) ? SW'(i + 1) : '0;
      if (hit_id_rt[i] && bus.stage_wr_ok[i])
        fwd_id_rt = (tnew_q[i] == '0) ? SW'(i + 1) : '0;
    end
    for (int i = DEPTH - 1; i >= 1; i--) begin
      if (hit_ex_rs[i] && bus.stage_wr_ok[i])
        fwd_ex_rs = (tnew_q[i] == '0) ? SW'(i + 1) : '0;
      if (hit_ex_rt[i] && bus.stage_wr_ok[i])
        fwd_ex_rt = (tnew_q[i] == '0) ? SW'(i + 1) : '0;
    end
  end

  always_comb begin
    dst_d[0]  = stall ? 5'd0 : bus.id_dst;
    we_d[0]   = stall ? 1'b0 : bus.id_we;
    tnew_d[0] = stall ? '0 : bus.id_tnew;
    for (int i = 1; i < DEPTH; i++) begin
      dst_d[i]  = dst_q[i-1];
      we_d[i]   = we_q[i-1];
      tnew_d[i] = (tnew_q[i-1] == '0) ? '0 : tnew_q[i-1] - 1'b1;
    end
    ex_rs_d = stall ? 5'd0 : bus.id_rs;
    ex_rt_d = stall ? 5'd0 : bus.id_rt;
  end

  // A start held in ID by a stall must not begin counting until it really issues.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (bus.id_md_start && !stall)
      md_cnt_d = bus.id_md_div ? MW'(DIV_CYCLES) : MW'(MUL_CYCLES);
    else if (md_cnt_q != '0)
      md_cnt_d = md_cnt_q - 1'b1;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        dst_q[i]  <= 5'd0;
        tnew_q[i] <= '0;
      end
      we_q        <= '0;
      ex_rs_q     <= 5'd0;
      ex_rt_q     <= 5'd0;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        dst_q[i]  <= dst_d[i];
        tnew_q[i] <= tnew_d[i];
      end
      we_q        <= we_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.md_busy     = md_busy;
  assign bus.fwd_id_rs   = fwd_id_rs;
  assign bus.fwd_id_rt   = fwd_id_rt;
  assign bus.fwd_ex_rs   = fwd_ex_rs;
  assign bus.fwd_ex_rt   = fwd_ex_rt;
  assign bus.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard; a narrow stall counter lets the
// saturation boundary be reached within a short run.
module tb_hazard_scoreboard;
  localparam int DEPTH = 3;
  localparam int TW    = 3;
  localparam int CNT_W = 4;

  logic clk;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;

  hazard_scoreboard_if #(.DEPTH(DEPTH), .TW(TW), .CNT_W(CNT_W)) bus ();

  hazard_scoreboard #(
    .DEPTH(DEPTH), .TW(TW), .MUL_CYCLES(5), .DIV_CYCLES(10), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %-16s got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %-16s = %0d", tag, got);
    end
  endtask

  task automatic clear_id();
    bus.id_rs       = 5'd0;
    bus.id_rt       = 5'd0;
    bus.id_tuse_rs  = '0;
    bus.id_tuse_rt  = '0;
    bus.id_dst      = 5'd0;
    bus.id_we       = 1'b0;
    bus.id_tnew     = '0;
    bus.id_md_start = 1'b0;
    bus.id_md_div   = 1'b0;
    bus.id_md_use   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_all_sel_zero(input string tag);
    chk_eq({tag, "_fidrs"}, bus.fwd_id_rs, 0);
    chk_eq({tag, "_fidrt"}, bus.fwd_id_rt, 0);
    chk_eq({tag, "_fexrs"}, bus.fwd_ex_rs, 0);
    chk_eq({tag, "_fexrt"}, bus.fwd_ex_rt, 0);
  endtask

  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    clear_id();
    bus.stage_wr_ok = 3'b111;
    #12;
    chk_eq("rst_stall", bus.stall, 0);
    chk_eq("rst_md_busy", bus.md_busy, 0);
    chk_eq("rst_count", bus.stall_count, 0);
    chk_all_sel_zero("rst");
    @(negedge clk);
    reset = 1'b0;
    tick();

    // mult issued, then mfhi waits out the 5 busy cycles
    bus.id_md_start = 1'b1;
    settle();
    chk_eq("mul_issue_stall", bus.stall, 0);
    tick();
    clear_id();
    bus.id_md_use = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk_eq($sformatf("mul_stall_%0d", i), bus.stall, 1);
      chk_eq($sformatf("mul_busy_%0d", i), bus.md_busy, 1);
      tick();
    end
    settle();
    chk_eq("mul_done_stall", bus.stall, 0);
    chk_eq("mul_done_busy", bus.md_busy, 0);
    chk_eq("mul_count", bus.stall_count, 5);

    // lw $1 (tnew 2) then addu rs=$1 (tuse 1)
    clear_id();
    bus.id_dst = 5'd1; bus.id_we = 1'b1; bus.id_tnew = 3'd2;
    tick();
    clear_id();
    bus.id_rs = 5'd1; bus.id_tuse_rs = 3'd1;
    bus.id_dst = 5'd6; bus.id_we = 1'b1; bus.id_tnew = 3'd1;
    bus.stage_wr_ok = 3'b000;
    settle();
    chk_eq("lw_stall_nomask", bus.stall, 1);
    bus.stage_wr_ok = 3'b111;
    tick();
    settle();
    chk_eq("lw_stall_gone", bus.stall, 0);
    chk_eq("lw_fwd_id_rs", bus.fwd_id_rs, 0);
    tick();
    clear_id();
    settle();
    chk_eq("lw_fwd_ex_rs", bus.fwd_ex_rs, 3);
    chk_eq("lw_count", bus.stall_count, 6);

    // addu $2 (tnew 1) then beq rs=$2 (tuse 0)
    bus.id_dst = 5'd2; bus.id_we = 1'b1; bus.id_tnew = 3'd1;
    tick();
    clear_id();
    bus.id_rs = 5'd2;
    settle();
    chk_eq("br_stall", bus.stall, 1);
    tick();
    settle();
    chk_eq("br_stall_gone", bus.stall, 0);
    chk_eq("br_fwd_id_rs", bus.fwd_id_rs, 2);
    tick();
    clear_id();
    settle();
    chk_eq("br_count", bus.stall_count, 7);

    // two writers of $3 in stages 1 and 2, selected by stage_wr_ok
    tick(); tick(); tick();
    bus.id_dst = 5'd3; bus.id_we = 1'b1; bus.id_tnew = 3'd0;
    tick();
    tick();
    clear_id();
    bus.id_rs = 5'd3; bus.id_rt = 5'd3;
    bus.stage_wr_ok = 3'b010;
    settle();
    chk_eq("cmov_stall", bus.stall, 0);
    chk_eq("cmov_rs_010", bus.fwd_id_rs, 2);
    bus.stage_wr_ok = 3'b011;
    settle();
    chk_eq("cmov_rs_011", bus.fwd_id_rs, 1);
    chk_eq("cmov_rt_011", bus.fwd_id_rt, 1);
    bus.stage_wr_ok = 3'b100;
    settle();
    chk_eq("cmov_rs_100", bus.fwd_id_rs, 0);
    bus.stage_wr_ok = 3'b111;
    tick();
    clear_id();
    settle();
    chk_eq("cmov_ex_rt_111", bus.fwd_ex_rt, 2);
    bus.stage_wr_ok = 3'b101;
    settle();
    chk_eq("cmov_ex_rt_101", bus.fwd_ex_rt, 3);
    bus.stage_wr_ok = 3'b111;

    // writer of $0 must never hit
    bus.id_dst = 5'd0; bus.id_we = 1'b1; bus.id_tnew = 3'd2;
    tick();
    clear_id();
    settle();
    chk_eq("r0_stall", bus.stall, 0);
    chk_eq("r0_fwd_id_rs", bus.fwd_id_rs, 0);

    // lw $5 then mult rt=$5: stalled start must not load the counter
    bus.id_dst = 5'd5; bus.id_we = 1'b1; bus.id_tnew = 3'd2;
    tick();
    clear_id();
    bus.id_rt = 5'd5; bus.id_md_start = 1'b1;
    settle();
    chk_eq("mdst_stall_0", bus.stall, 1);
    chk_eq("mdst_busy_0", bus.md_busy, 0);
    tick();
    settle();
    chk_eq("mdst_stall_1", bus.stall, 1);
    chk_eq("mdst_busy_1", bus.md_busy, 0);
    tick();
    settle();
    chk_eq("mdst_stall_2", bus.stall, 0);
    chk_eq("mdst_fwd_id_rt", bus.fwd_id_rt, 3);
    tick();
    clear_id();
    settle();
    chk_eq("mdst_busy_on", bus.md_busy, 1);
    chk_eq("mdst_count", bus.stall_count, 9);

    // let the multiply drain, then divide with mfhi waiting; counter saturates
    for (int i = 0; i < 5; i++) tick();
    settle();
    chk_eq("drain_busy", bus.md_busy, 0);
    bus.id_md_start = 1'b1; bus.id_md_div = 1'b1;
    tick();
    clear_id();
    bus.id_md_use = 1'b1;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk_eq($sformatf("div_stall_%0d", i), bus.stall, 1);
      tick();
    end
    settle();
    chk_eq("div_count_max", bus.stall_count, 15);
    tick();
    settle();
    chk_eq("div_count_sat", bus.stall_count, 15);
    chk_eq("div_busy_mid", bus.md_busy, 1);

    // asynchronous reset with the divider at 3 cycles remaining
    clear_id();
    #1;
    reset = 1'b1;
    #1;
    chk_eq("arst_busy", bus.md_busy, 0);
    chk_eq("arst_count", bus.stall_count, 0);
    chk_eq("arst_stall", bus.stall, 0);
    chk_all_sel_zero("arst");
    @(negedge clk);
    reset = 1'b0;
    tick();
    bus.id_md_use = 1'b1;
    settle();
    chk_eq("post_rst_stall", bus.stall, 0);
    chk_eq("post_rst_busy", bus.md_busy, 0);
    tick();
    settle();
    chk_eq("post_rst_count", bus.stall_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter DEPTH, default 3: pipeline stages after ID that are tracked (1=EX, 2=MEM, 3=WB, ...); SHALL be >=2.
REQ-002 Parameter TW, default 3: width of every Tuse/Tnew value.
REQ-003 Parameter MUL_CYCLES, default 5: busy cycles of a multiply.
REQ-004 Parameter DIV_CYCLES, default 10: busy cycles of a divide.
REQ-005 Parameter CNT_W, default 32: width of the stall counter.
REQ-006 Local SW = clog2(DEPTH+1): forward-select width; code 0 = register file, code k = stage k.
REQ-007 clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 reset  in  1  asynchronous, active-high.
REQ-009 id_rs, id_rt  in  5  source registers of the ID instruction.
REQ-010 id_tuse_rs, id_tuse_rt  in  TW  cycles after ID before each source is consumed.
REQ-011 id_dst  in  5, id_we  in  1, id_tnew  in  TW  destination, write enable, and cycles after entering stage 1 until the result exists.
REQ-012 id_md_start  in  1 (ID is mult/div), id_md_div  in  1 (1=divide), id_md_use  in  1 (ID reads/writes HI/LO).
REQ-013 stage_wr_ok  in  DEPTH  bit k-1 = stage k will actually write (conditional-move qualifier).
REQ-014 stall  out  1  freeze PC/IF-ID and insert bubble into stage 1.
REQ-015 fwd_id_rs, fwd_id_rt  out  SW  ID forward selects.
REQ-016 fwd_ex_rs, fwd_ex_rt  out  SW  stage-1 (EX) forward selects.
REQ-017 md_busy  out  1;  stall_count  out  CNT_W.

Function
REQ-018 Block SHALL hold shadow registers dst_k, we_k, tnew_k for k=1..DEPTH, plus ex_rs, ex_rt.
REQ-019 Each edge: stage 1 <= stall ? {0,0,0} : {id_dst,id_we,id_tnew}; ex_rs/ex_rt <= stall ? 0 : id_rs/id_rt.
REQ-020 Each edge, k>=2: stage k <= stage k-1 with tnew saturating-decremented (0 stays 0).
REQ-021 hit_k(r) = (r!=0) && r==dst_k && we_k; register 0 SHALL never hit.
REQ-022 Data stall SHALL assert, combinationally, when for any source s of ID and any k, hit_k(s) && tuse_s < tnew_k; stage_wr_ok SHALL NOT mask stalls.
REQ-023 md counter: if id_md_start && !stall, load DIV_CYCLES when id_md_div, else MUL_CYCLES; else if nonzero, decrement by 1.
REQ-024 md_busy = (counter != 0).
REQ-025 MD stall SHALL assert when (id_md_use || id_md_start) && (md_busy || we... stage-1 holds an unissued start is impossible), i.e. when (id_md_use || id_md_start) && md_busy.
REQ-026 stall = data stall OR md stall.
REQ-027 fwd_id_s: smallest k in 1..DEPTH with hit_k(s) && stage_wr_ok[k-1]; output k if tnew_k==0, else 0; output 0 when no such k.
REQ-028 fwd_ex_s: same rule over k=2..DEPTH using ex_rs/ex_rt.
REQ-029 Stages with stage_wr_ok=0 SHALL be skipped, so the search continues to older stages.
REQ-030 stall_count SHALL increment on every edge where stall=1, saturating at all-ones.
REQ-031 A simultaneous stall and id_md_start SHALL NOT load the counter.

Reset
REQ-032 On reset, all shadow registers, ex_rs, ex_rt, the md counter and stall_count SHALL clear immediately, independent of clk.
REQ-033 While reset is held with ID inputs 0: stall=0, md_busy=0, all forward selects=0.
REQ-034 Reset asserted mid multiply/divide SHALL abandon it; no stall persists after release.

Verification
REQ-035 lw $1 (tnew 2), then addu rs=$1 (tuse 1) -> 1 stall cycle; next cycle fwd_id_rs=0; following cycle fwd_ex_rs=3.
REQ-036 addu $2 (tnew 1), then beq rs=$2 (tuse 0) -> 1 stall cycle, then fwd_id_rs=2.
REQ-037 mult issued, then mfhi in ID (MUL_CYCLES=5) -> md_busy 5 cycles, stall 5 cycles, stall_count=5.
REQ-038 Stage 1 and stage 2 both dst $3, tnew 0; stage_wr_ok=3'b010, id_rs=3 -> fwd_id_rs=2; stage_wr_ok=3'b011 -> fwd_id_rs=1.
REQ-039 Stage 1 dst $0, we 1, tnew 2; id_rs=0 -> stall=0, fwd_id_rs=0.
REQ-040 div issued, counter=3, reset pulsed -> md_busy=0, stall_count=0, all selects 0 immediately.
